// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: job sequencer for the serial deterministic-stochastic
// 3-input multiplier. It takes operand triples over valid/ready, runs one
// multiplication (clear, then enable until ov or watchdog expiry), and
// returns the product, the run-cycle count and a timeout flag over
// valid/ready. It also keeps saturating job/cycle statistics.
module dsc_mul_seq #(
  parameter int WIDTH      = 6,
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 300000,
  parameter int CLR_CYCLES = 1,
  parameter int ACC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WIDTH-1:0]   out_z,
  output logic [CNT_W-1:0]     out_cycles,
  output logic                 out_timeout,
  output logic                 mul_rst,
  output logic                 mul_en,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_c,
  input  logic [3*WIDTH-1:0]   mul_z,
  input  logic                 mul_ov,
  output logic [15:0]          stat_jobs,
  output logic [ACC_W-1:0]     stat_cycles
);

  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] TO_V     = CNT_W'(TIMEOUT);
  localparam logic [3:0]       CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam int               SUM_W    = ACC_W + 1;

  // Parameter sanity: the run counter must never wrap before the watchdog.
  if (TIMEOUT < 1 || longint'(TIMEOUT) > longint'(MAX_CNT)) begin : g_bad_timeout
    $error("dsc_mul_seq: TIMEOUT must be in 1..2^CNT_W-1");
  end
  if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr
    $error("dsc_mul_seq: CLR_CYCLES must be in 1..15");
  end
  if (ACC_W < CNT_W) begin : g_bad_acc
    $error("dsc_mul_seq: ACC_W must be at least CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               mul_rst_q, mul_rst_d;
  logic               mul_en_q, mul_en_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         clr_q, clr_d;
  logic [3*WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               to_q, to_d;
  logic [15:0]        jobs_q, jobs_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   k_s;
  logic [SUM_W-1:0]   sum_s;

  // Next-state, captured-result, statistics and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    z_d     = z_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    jobs_d  = jobs_q;
    acc_d   = acc_q;
    sum_s   = '0;
    // k_s is the 1-based index of the current RUN cycle.
    k_s     = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          cnt_d   = '0;
          clr_d   = 4'd0;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clr_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_d = clr_q + 4'd1;
        end
      end
      S_RUN: begin
        // ov takes priority over a watchdog expiry in the same cycle.
        if (mul_ov) begin
          z_d     = mul_z;
          cyc_d   = k_s;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (k_s == TO_V) begin
          z_d     = mul_z;
          cyc_d   = TO_V;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = k_s;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Statistics advance once per job, on the edge that enters DONE.
    if (state_q == S_RUN && state_d == S_DONE) begin
      jobs_d = (jobs_q == 16'hFFFF) ? jobs_q : jobs_q + 16'd1;
      sum_s  = {1'b0, acc_q} + SUM_W'(cyc_d);
      acc_d  = sum_s[ACC_W] ? '1 : sum_s[ACC_W-1:0];
    end else begin
      jobs_d = jobs_q;
      acc_d  = acc_q;
    end

    // Handshake and multiplier controls follow the state being entered.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    mul_rst_d   = (state_d != S_RUN);
    mul_en_d    = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mul_rst_q   <= 1'b1;
      mul_en_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      clr_q       <= 4'd0;
      z_q         <= '0;
      cyc_q       <= '0;
      to_q        <= 1'b0;
      jobs_q      <= 16'd0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mul_rst_q   <= mul_rst_d;
      mul_en_q    <= mul_en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      z_q         <= z_d;
      cyc_q       <= cyc_d;
      to_q        <= to_d;
      jobs_q      <= jobs_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_z       = z_q;
  assign out_cycles  = cyc_q;
  assign out_timeout = to_q;
  assign mul_rst     = mul_rst_q;
  assign mul_en      = mul_en_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_c       = c_q;
  assign stat_jobs   = jobs_q;
  assign stat_cycles = acc_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Bench for dsc_mul_seq. Two sequencers (CLR_CYCLES=1 and 3, TIMEOUT=50),
// each driving a behavioural multiplier stub: ov rises on RUN cycle L,
// z = a*b*c. Expected results come from the job parameters alone.
module tb_dsc_mul_seq;

  localparam int TO = 50;

  logic        clk;
  logic        rst;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic        out_timeout[2], mul_rst[2], mul_en[2], mul_ov[2];
  logic [5:0]  in_a[2], in_b[2], in_c[2], mul_a[2], mul_b[2], mul_c[2];
  logic [17:0] out_z[2], mul_z[2];
  logic [19:0] out_cycles[2];
  logic [15:0] stat_jobs[2];
  logic [31:0] stat_cycles[2];

  int          stub_l[2];
  logic        stub_never[2], stub_force[2];

  int          n_chk, n_pass;
  longint      exp_jobs[2], exp_cyc[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_u
    int ecnt;

    dsc_mul_seq #(
      .WIDTH(6), .CNT_W(20), .TIMEOUT(TO),
      .CLR_CYCLES((g == 0) ? 1 : 3), .ACC_W(32)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_c(in_c[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_z(out_z[g]), .out_cycles(out_cycles[g]), .out_timeout(out_timeout[g]),
      .mul_rst(mul_rst[g]), .mul_en(mul_en[g]),
      .mul_a(mul_a[g]), .mul_b(mul_b[g]), .mul_c(mul_c[g]),
      .mul_z(mul_z[g]), .mul_ov(mul_ov[g]),
      .stat_jobs(stat_jobs[g]), .stat_cycles(stat_cycles[g])
    );

    // Stub: count enabled cycles since the last multiplier reset.
    always_ff @(posedge clk) begin
      if (mul_rst[g]) ecnt <= 0;
      else if (mul_en[g]) ecnt <= ecnt + 1;
    end

    assign mul_ov[g] = stub_force[g] |
                       (mul_en[g] & ~stub_never[g] & ((ecnt + 1) >= stub_l[g]));
    assign mul_z[g]  = 18'(mul_a[g]) * 18'(mul_b[g]) * 18'(mul_c[g]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present a triple and wait for it to be taken; returns at the negedge
  // after the accepting edge, with the input bus scrambled.
  task automatic start_job(input int u, input logic [5:0] a, b, c);
    bit ok = 1'b0;
    @(negedge clk);
    in_a[u] = a; in_b[u] = b; in_c[u] = c; in_valid[u] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready[u]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", ok, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_a[u] = 6'($urandom); in_b[u] = 6'($urandom); in_c[u] = 6'($urandom);
    chk("in_ready_busy", in_ready[u], 0);
  endtask

  // Follow a started job to DONE, check it against the model, hold the
  // result for 'hold' cycles under backpressure, then retire it.
  task automatic finish_job(input int u, input logic [5:0] a, b, c,
                            input int l, input bit never, input int hold);
    int     clr = 0, run = 0;
    bit     got = 1'b0, op_ok = 1'b1, stable = 1'b1;
    bit     exp_to;
    longint exp_k, exp_z;
    logic [17:0] z0;
    logic [19:0] k0;
    exp_to = never || (l > TO);
    exp_k  = exp_to ? TO : l;
    exp_z  = longint'(a) * longint'(b) * longint'(c);
    for (int i = 0; i < 500; i++) begin
      if (out_valid[u]) begin got = 1'b1; break; end
      if (mul_en[u]) run++;
      else if (mul_rst[u]) clr++;
      if (mul_a[u] !== a || mul_b[u] !== b || mul_c[u] !== c) op_ok = 1'b0;
      @(negedge clk);
    end
    exp_jobs[u]++;
    exp_cyc[u] += exp_k;
    chk("done_seen", got, 1);
    chk("out_z", out_z[u], exp_z);
    chk("out_cycles", out_cycles[u], exp_k);
    chk("out_timeout", out_timeout[u], exp_to);
    chk("clear_cycles", clr, (u == 0) ? 1 : 3);
    chk("run_cycles", run, exp_k);
    chk("operands_stable", op_ok, 1);
    chk("stat_jobs", stat_jobs[u], exp_jobs[u]);
    chk("stat_cycles", stat_cycles[u], exp_cyc[u]);
    chk("done_mul_en", mul_en[u], 0);
    if (hold > 0) begin
      z0 = out_z[u]; k0 = out_cycles[u];
      in_a[u] = ~a; in_valid[u] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_z[u] !== z0 || out_cycles[u] !== k0 || !out_valid[u]) stable = 1'b0;
        if (in_ready[u] || mul_en[u] || mul_a[u] !== a) stable = 1'b0;
      end
      in_valid[u] = 1'b0;
      chk("backpressure_hold", stable, 1);
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk("retire_valid", out_valid[u], 0);
    chk("retire_ready", in_ready[u], 1);
  endtask

  task automatic job(input int u, input logic [5:0] a, b, c,
                     input int l, input bit never, input int hold);
    stub_l[u] = l; stub_never[u] = never;
    start_job(u, a, b, c);
    finish_job(u, a, b, c, l, never, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    logic [5:0] ra, rb, rc;
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b0;
      in_a[u] = 6'd0; in_b[u] = 6'd0; in_c[u] = 6'd0;
      stub_l[u] = 1; stub_never[u] = 1'b0; stub_force[u] = 1'b0;
      exp_jobs[u] = 0; exp_cyc[u] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_mul_rst", mul_rst[0], 1);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_out_z", out_z[0], 0);
    chk("rst_stats", {stat_jobs[0], stat_cycles[0]}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready[0], 1);

    // Single job with 20 cycles of result backpressure.
    job(0, 6'd3, 6'd4, 6'd5, 5, 1'b0, 20);
    // Watchdog expiry, then a normal job.
    job(0, 6'd63, 6'd63, 6'd63, 0, 1'b1, 0);
    job(0, 6'd1, 6'd2, 6'd3, 4, 1'b0, 0);
    // ov exactly on the watchdog cycle, then one cycle too late.
    job(0, 6'd2, 6'd3, 6'd4, TO, 1'b0, 0);
    job(0, 6'd5, 6'd6, 6'd7, TO + 1, 1'b0, 2);

    // Reset in RUN cycle 3 of 10, with ov stuck high across reset and idle.
    stub_l[0] = 10; stub_never[0] = 1'b0;
    start_job(0, 6'd9, 6'd9, 6'd9);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (mul_en[0]) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    chk("reached_run3", n, 3);
    stub_force[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready[0], 0);
    chk("midrst_mul_en", mul_en[0], 0);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin exp_jobs[u] = 0; exp_cyc[u] = 0; end
    @(negedge clk);
    chk("midrst_idle_ready", in_ready[0], 1);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_stats", {stat_jobs[0], stat_cycles[0]}, 0);
    chk("midrst_mul_rst", mul_rst[0], 1);
    chk("midrst_mul_a", mul_a[0], 0);
    repeat (4) @(negedge clk);
    chk("stuck_ov_ignored", {out_valid[0], in_ready[0], mul_en[0]}, 3'b010);
    stub_force[0] = 1'b0;
    job(0, 6'd63, 6'd63, 6'd63, 7, 1'b0, 0);

    // Random jobs on both sequencers.
    for (int u = 0; u < 2; u++) begin
      for (int j = 0; j < 10; j++) begin
        ra = 6'($urandom); rb = 6'($urandom); rc = 6'($urandom);
        job(u, ra, rb, rc, int'($urandom_range(1, 40)), 1'b0,
            int'($urandom_range(0, 3)));
      end
    end
    chk("u1_jobs_total", stat_jobs[1], 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
